// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush arbiter for the 5-stage pipeline.
// Drives per-stage enables, flush/bubble controls and saturating event counters.
module pipeline_sequencer #(
    parameter int MD_CYCLES = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             md_start,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT} state_t;
    localparam logic [7:0] MD_INIT = 8'(MD_CYCLES - 1);
    state_t state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic pend_q, pend_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic [4:0] en;
    logic flush, bubble, busy, redir, run_eval;
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        pend_d   = pend_q;
        en       = 5'b11111;
        flush    = 1'b0;
        bubble   = 1'b0;
        busy     = 1'b0;
        redir    = redirect;
        run_eval = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    en      = 5'b00000;
                    state_d = MEM_WAIT;
                    pend_d  = redirect;
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ack) begin
                    en = 5'b00000;
                end else begin
                    run_eval = 1'b1;
                    redir    = pend_q | redirect;
                    pend_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            MD_WAIT: begin
                busy = 1'b1;
                if (mem_req && !mem_ack) begin
                    en = 5'b00000;
                end else begin
                    en       = 5'b00011;
                    md_cnt_d = md_cnt_q - 8'd1;
                    state_d  = (md_cnt_q == 8'd1) ? RUN : MD_WAIT;
                end
            end
            default: state_d = RUN;
        endcase
        // Run-cycle arbitration: mul/div > redirect > load-use
        if (run_eval) begin
            if (md_start) begin
                en       = 5'b00011;
                md_cnt_d = MD_INIT;
                state_d  = MD_WAIT;
            end else if (redir) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (load_use) begin
                en     = 5'b00111;
                bubble = 1'b1;
            end
        end
        if (!rst_n) begin
            en     = 5'b00000;
            flush  = 1'b0;
            bubble = 1'b0;
            busy   = 1'b0;
        end
        stall_d = (!en[4] && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            pend_q   <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            pend_q   <= pend_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end
    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
    assign flush_if_id  = flush;
    assign bubble_id_ex = bubble;
    assign md_busy      = busy;
    assign stall_cnt    = stall_q;
    assign flush_cnt    = flush_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed scoreboard bench for the stall/flush sequencer.
// A second instance with 4-bit counters covers saturation.
module tb_pipeline_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic load_use = 1'b0, redirect = 1'b0, mem_req = 1'b0, mem_ack = 1'b0, md_start = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, flush_if_id, bubble_id_ex, md_busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en, s_flush, s_bubble, s_busy;
    logic [3:0] s_stall_cnt, s_flush_cnt;
    int errors = 0, checks = 0;
    logic [7:0] q[$];

    // Expected output vectors: {pc,if_id,id_ex,ex_mem,mem_wb,flush,bubble,md_busy}
    localparam logic [7:0] ALL1 = 8'b11111_000;
    localparam logic [7:0] LU   = 8'b00111_010;
    localparam logic [7:0] RED  = 8'b11111_110;
    localparam logic [7:0] MD0  = 8'b00011_000;
    localparam logic [7:0] MDB  = 8'b00011_001;
    localparam logic [7:0] MDF  = 8'b00000_001;
    localparam logic [7:0] ZERO = 8'b00000_000;

    pipeline_sequencer #(.MD_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .redirect(redirect),
        .mem_req(mem_req), .mem_ack(mem_ack), .md_start(md_start),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_sequencer #(.MD_CYCLES(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .redirect(redirect),
        .mem_req(mem_req), .mem_ack(mem_ack), .md_start(md_start),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
        .mem_wb_en(s_mem_wb_en), .flush_if_id(s_flush), .bubble_id_ex(s_bubble),
        .md_busy(s_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic cmp_out(input string tag);
        logic [7:0] exp, obs;
        exp = q.pop_front();
        obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, flush_if_id, bubble_id_ex, md_busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic lu, input logic rd, input logic mr,
                       input logic ma, input logic ms, input logic [7:0] exp);
        load_use = lu; redirect = rd; mem_req = mr; mem_ack = ma; md_start = ms;
        q.push_back(exp);
        @(negedge clk);
        cmp_out(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        load_use = 0; redirect = 0; mem_req = 0; mem_ack = 0; md_start = 0;
        rst_n = 1'b0;
        #1;
        q.push_back(ZERO);
        cmp_out(tag);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk({tag, "_stall"}, int'(stall_cnt), 0);
        chk({tag, "_flush"}, int'(flush_cnt), 0);
    endtask

    initial begin
        #2;
        apply_reset("por");
        cyc("idle", 0, 0, 0, 0, 0, ALL1);
        cyc("memreq_ack", 0, 0, 1, 1, 0, ALL1);
        // Single load-use stall
        cyc("lu_stall", 1, 0, 0, 0, 0, LU);
        cyc("lu_after", 0, 0, 0, 0, 0, ALL1);
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        chk("lu_flush_cnt", int'(flush_cnt), 0);
        // Redirect wins over load-use
        apply_reset("rst_b");
        cyc("red_lu", 1, 1, 0, 0, 0, RED);
        chk("red_flush_cnt", int'(flush_cnt), 1);
        chk("red_stall_cnt", int'(stall_cnt), 0);
        // Mul/div: 8 stall cycles, md_start ignored while busy
        apply_reset("rst_c");
        cyc("md_start", 0, 0, 0, 0, 1, MD0);
        for (int i = 0; i < 7; i++) cyc($sformatf("md_wait%0d", i), 0, 0, 0, 0, i == 2, MDB);
        cyc("md_done", 0, 0, 0, 0, 0, ALL1);
        chk("md_stall_cnt", int'(stall_cnt), 8);
        // Memory wait with redirect captured in the first cycle
        apply_reset("rst_d");
        cyc("mw0", 0, 1, 1, 0, 0, ZERO);
        cyc("mw1", 0, 0, 1, 0, 0, ZERO);
        cyc("mw2", 0, 0, 1, 0, 0, ZERO);
        cyc("mw_ack", 0, 0, 1, 1, 0, RED);
        cyc("mw_after", 0, 0, 0, 0, 0, ALL1);
        chk("mw_flush_cnt", int'(flush_cnt), 1);
        chk("mw_stall_cnt", int'(stall_cnt), 3);
        // Memory stall during mul/div freezes the countdown
        apply_reset("rst_e");
        cyc("mdf_start", 0, 0, 0, 0, 1, MD0);
        cyc("mdf_freeze", 0, 0, 1, 0, 0, MDF);
        for (int i = 0; i < 7; i++) cyc($sformatf("mdf_wait%0d", i), 0, 0, 0, 0, 0, MDB);
        cyc("mdf_done", 0, 0, 0, 0, 0, ALL1);
        chk("mdf_stall_cnt", int'(stall_cnt), 9);
        // Saturation on the 4-bit instance
        apply_reset("rst_f");
        for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), 1, 0, 0, 0, 0, LU);
        chk("sat_small", int'(s_stall_cnt), 15);
        chk("sat_big", int'(stall_cnt), 20);
        // Reset mid mul/div wait with counter at 5
        apply_reset("rst_g");
        cyc("mdr_start", 0, 0, 0, 0, 1, MD0);
        cyc("mdr_w0", 0, 0, 0, 0, 0, MDB);
        cyc("mdr_w1", 0, 0, 0, 0, 0, MDB);
        apply_reset("mdr_reset");
        cyc("mdr_run", 0, 0, 0, 0, 0, ALL1);
        cyc("mdr_run2", 0, 0, 0, 0, 0, ALL1);
        chk("mdr_stall_cnt", int'(stall_cnt), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Arbitrates four stall/flush sources and drives per-stage register enables and flush/bubble controls:
  - load-use stall request from hazard detection
  - control-flow redirect (next-PC source not PC+4)
  - data-memory wait handshake
  - fixed-latency multi-cycle mul/div unit
- Also keeps saturating event counters for performance debug.

Parameters:
- MD_CYCLES, 8, EX-stage cycles a mul/div occupies; legal range 2..255.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_use  input  1  load-use stall request (ID needs result of load in EX)
- redirect  input  1  EX resolved next PC is not PC+4; IF/ID and ID/EX hold wrong-path instructions
- mem_req  input  1  MEM stage instruction performs a data-memory access this cycle
- mem_ack  input  1  data memory completes the access this cycle
- md_start  input  1  EX stage holds a mul/div instruction, first cycle
- pc_en  output  1  PC register update enable
- if_id_en  output  1  IF/ID load enable
- id_ex_en  output  1  ID/EX load enable
- ex_mem_en  output  1  EX/MEM load enable
- mem_wb_en  output  1  MEM/WB load enable
- flush_if_id  output  1  IF/ID loads NOP (when enabled)
- bubble_id_ex  output  1  ID/EX loads NOP (when enabled)
- md_busy  output  1  mul/div in progress
- stall_cnt  output  CNT_W  cycles with pc_en=0 while out of reset
- flush_cnt  output  CNT_W  redirects applied

Behaviour:
- States: RUN, MEM_WAIT, MD_WAIT. Reset state is RUN.
- Enables and flush/bubble outputs are combinational from state, inputs and pend_redir. Counters and state are registered.
- Async reset (rst_n=0):
  - state=RUN, md counter=0, pend_redir=0, counters=0.
  - All enables, flush_if_id, bubble_id_ex and md_busy forced 0 while rst_n=0.
  - Asserting reset mid-wait abandons the wait with no pending action.
- Priority in RUN: memory wait > mul/div > redirect > load-use.
- RUN, mem_req=1 and mem_ack=0:
  - All five enables=0 this cycle.
  - Next state MEM_WAIT.
  - Latch pend_redir=redirect.
- RUN, mem_req=mem_ack=1: no stall from memory.
- MEM_WAIT:
  - All enables 0 until the cycle mem_ack=1.
  - In the ack cycle, evaluate as RUN ignoring mem_req. pend_redir OR redirect acts as redirect. Clear pend_redir. Next state RUN.
- RUN, md_start=1 (no memory stall):
  - pc_en=if_id_en=id_ex_en=0; ex_mem_en=mem_wb_en=1.
  - Load md counter with MD_CYCLES-1; next state MD_WAIT.
  - EX/MEM receives a bubble; the EX stage zeroes its control outputs when md_busy=1.
- MD_WAIT:
  - md_busy=1. Same enables as the md_start cycle. Decrement the counter each cycle.
  - When the counter is 1, next state RUN. The mul/div instruction advances in the following RUN cycle, giving MD_CYCLES total stall cycles.
  - md_start is ignored in MD_WAIT.
  - mem_req without mem_ack in MD_WAIT freezes all stages; the counter also holds.
- Redirect in RUN:
  - All enables 1, flush_if_id=1, bubble_id_ex=1.
  - load_use in the same cycle is ignored because its instruction is squashed.
  - flush_cnt increments.
- Load-use in RUN (no higher-priority source):
  - pc_en=if_id_en=0; id_ex_en=1 with bubble_id_ex=1; ex_mem_en=mem_wb_en=1.
  - Exactly one stall cycle per assertion cycle; the upstream detector deasserts once the load advances.
- Otherwise all enables 1, flush/bubble 0.
- Counters saturate at all-ones and never wrap. stall_cnt increments every cycle pc_en=0 with rst_n=1.

Test Plan:
- Reset: rst_n=0 mid-MD_WAIT (counter=5) → immediately all outputs 0; after release state RUN, all enables 1, counters 0.
- Load-use: load_use=1 for one cycle → pc_en=0, if_id_en=0, bubble_id_ex=1, id_ex_en=1; next cycle all enables 1; stall_cnt=1.
- Redirect and load-use same cycle: redirect=1, load_use=1 → all enables 1, flush_if_id=1, bubble_id_ex=1; flush_cnt=1, stall_cnt=0.
- Mul/div, MD_CYCLES=8: md_start pulse → pc_en=0 for exactly 8 cycles; md_busy=1 for cycles 2-8; ex_mem_en=1 throughout; stall_cnt=8.
- Memory wait with redirect: mem_req=1, mem_ack low 3 cycles, redirect=1 in first cycle only → all enables 0 for 3 cycles; on ack cycle flush_if_id=1, bubble_id_ex=1, enables 1; flush_cnt=1.
- Saturation: CNT_W=4, hold load_use=1 for 20 cycles → stall_cnt stops at 15 with no wrap.
